wb_cmd_master: RTL and testbench



---
 rtl/wb_cmd_master_if.sv | 41 ++++
 rtl/wb_cmd_master.sv | 155 +++++++++++++++
 tb/tb_wb_cmd_master.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_master_if.sv
// ============================================================================
// wb_cmd_master_if : command/response stream plus Wishbone classic bus bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface wb_cmd_master_if #(
    parameter int ADR_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [ADR_W-1:0] cmd_adr;
    logic [31:0]      cmd_dat;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_dat;
    logic             rsp_err;
    logic             wb_cyc;
    logic             wb_stb;
    logic             wb_we;
    logic [ADR_W-1:0] wb_adr;
    logic [31:0]      wb_dat_o;
    logic [31:0]      wb_dat_i;
    logic             wb_ack;
    logic [15:0]      err_cnt;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, wb_dat_i, wb_ack,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, err_cnt
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, wb_dat_i, wb_ack,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, err_cnt
    );
endinterface

`default_nettype wire

// File: rtl/wb_cmd_master.sv
// ============================================================================
// wb_cmd_master : valid/ready commands -> single Wishbone classic cycles
// Optional watchdog/err_cnt enabled by macro WBM_TIMEOUT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module wb_cmd_master #(
    parameter int ADR_W       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    wb_cmd_master_if.master bus
);

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("wb_cmd_master: TIMEOUT_CYC must be within 2..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             ready_q, ready_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [31:0]      wdat_q, wdat_d;
    logic [31:0]      rdat_q, rdat_d;
    logic             err_q, err_d;
    logic             expire;

`ifdef WBM_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] wdog_q, wdog_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    assign expire = (wdog_q == WDOG_LAST);

    // Watchdog runs only in WAIT; an ack on the expiry edge suppresses the timeout.
    always_comb begin
        wdog_d    = wdog_q;
        err_cnt_d = err_cnt_q;
        if (state_q == ST_WAIT) begin
            if (!bus.wb_ack) begin
                if (expire) begin
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
        end else begin
            wdog_d = '0;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            wdog_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            wdog_q    <= wdog_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign expire      = 1'b0;
    assign bus.err_cnt = '0;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    we_d    = bus.cmd_we;
                    adr_d   = bus.cmd_adr;
                    wdat_d  = bus.cmd_dat;
                    cyc_d   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.wb_ack) begin
                    cyc_d   = 1'b0;
                    rdat_d  = we_q ? 32'd0 : bus.wb_dat_i;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (expire) begin
                    cyc_d   = 1'b0;
                    rdat_d  = 32'hFFFF_FFFF;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so that ready stays low while reset is asserted.
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_dat   = rdat_q;
    assign bus.rsp_err   = err_q;
    assign bus.wb_cyc    = cyc_q;
    assign bus.wb_stb    = cyc_q;
    assign bus.wb_we     = we_q;
    assign bus.wb_adr    = adr_q;
    assign bus.wb_dat_o  = wdat_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
// ============================================================================
// tb_wb_cmd_master : directed vector bench with a registered-ack CSR slave
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_cmd_master;
    localparam int ADR_W = 16;
    localparam int TMO   = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_cmd_master_if #(.ADR_W(ADR_W)) bus ();

    wb_cmd_master #(.ADR_W(ADR_W), .TIMEOUT_CYC(TMO)) dut (
        .wb_clk  (clk),
        .wb_rst_n(rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Slave: ack rises ack_dly cycles after stb is first seen and stays up one
    // cycle past the strobe, which reproduces the repeated registered ack.
    logic [31:0] mem [4] = '{default: 32'd0};
    logic        s_ack     = 1'b0;
    int          s_cnt     = 0;
    int          ack_dly   = 0;
    logic        never_ack = 1'b0;
    logic        force_ack = 1'b0;

    always @(posedge clk) begin
        if (bus.wb_stb && !never_ack) begin
            if (s_cnt >= ack_dly) begin
                s_ack <= 1'b1;
                if (bus.wb_we) mem[bus.wb_adr[1:0]] <= bus.wb_dat_o;
            end else begin
                s_ack <= 1'b0;
                s_cnt <= s_cnt + 1;
            end
        end else begin
            s_ack <= 1'b0;
            s_cnt <= 0;
        end
    end

    assign bus.wb_ack   = s_ack | force_ack;
    assign bus.wb_dat_i = mem[bus.wb_adr[1:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_cmd(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                          input int stall, output logic [31:0] rdat, output logic err,
                          output int lat, output int stb_cyc, output logic hold_ok);
        int guard;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_bound", {31'd0, guard < 50}, 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 1; stb_cyc = 0; hold_ok = 1'b1;
        while (!bus.rsp_valid && lat < 1000) begin
            if (bus.wb_stb) stb_cyc++;
            if (bus.wb_cyc !== bus.wb_stb || bus.wb_adr !== adr || bus.wb_we !== we ||
                bus.wb_dat_o !== dat || bus.cmd_ready !== 1'b0) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("rsp_bound", {31'd0, lat < 1000}, 32'd1);
        if (bus.wb_cyc !== 1'b0 || bus.wb_stb !== 1'b0) hold_ok = 1'b0;
        rdat = bus.rsp_dat;
        err  = bus.rsp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== rdat || bus.rsp_err !== err ||
                bus.cmd_ready !== 1'b0 || bus.wb_stb !== 1'b0) hold_ok = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) hold_ok = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [31:0] dat;
        int          dly;
        int          stall;
        logic [31:0] exp_rdat;
        int          exp_lat;
        int          exp_stb;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] rdat;
    logic        err;
    int          lat, stbc, n_acc, n_rsp;
    int          acc [2];
    logic        hok, quiet;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 16'h0001, 32'h8000_0123, 0, 0, 32'h0000_0000, 3, 2};
        vecs[1] = '{1'b0, 16'h0001, 32'h0000_0000, 0, 5, 32'h8000_0123, 3, 2};
        vecs[2] = '{1'b1, 16'h0002, 32'hDEAD_BEEF, 2, 0, 32'h0000_0000, 5, 4};
        vecs[3] = '{1'b0, 16'h0002, 32'h0000_0000, 3, 0, 32'hDEAD_BEEF, 6, 5};
        vecs[4] = '{1'b1, 16'h0001, 32'h0000_5A5A, 1, 1, 32'h0000_0000, 4, 3};
        vecs[5] = '{1'b0, 16'h0001, 32'h0000_0000, 0, 0, 32'h0000_5A5A, 3, 2};
        vecs[6] = '{1'b0, 16'hFFFE, 32'h0000_0000, 1, 2, 32'hDEAD_BEEF, 4, 3};

        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = '0; bus.cmd_dat = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("rst_cyc_stb",   {30'd0, bus.wb_cyc, bus.wb_stb}, 32'd0);
        check("rst_we",        {31'd0, bus.wb_we}, 32'd0);
        check("rst_adr",       {16'd0, bus.wb_adr}, 32'd0);
        check("rst_dat_o",     bus.wb_dat_o, 32'd0);
        check("rst_rsp",       {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
        check("rst_rsp_dat",   bus.rsp_dat, 32'd0);
        check("rst_err_cnt",   {16'd0, bus.err_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            ack_dly = vecs[i].dly;
            do_cmd(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].stall, rdat, err, lat, stbc, hok);
            check($sformatf("v%0d_rsp_dat", i), rdat, vecs[i].exp_rdat);
            check($sformatf("v%0d_rsp_err", i), {31'd0, err}, 32'd0);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_stb_cycles", i), stbc, vecs[i].exp_stb);
            check($sformatf("v%0d_hold", i), {31'd0, hok}, 32'd1);
            if (vecs[i].we)
                check($sformatf("v%0d_slave_reg", i), mem[vecs[i].adr[1:0]], vecs[i].dat);
        end

        // Ack while idle must not start or answer anything.
        @(negedge clk);
        force_ack = 1'b1;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.wb_cyc !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) quiet = 1'b0;
        end
        force_ack = 1'b0;
        check("idle_ack_ignored", {31'd0, quiet}, 32'd1);

        // Back-to-back reads with rsp_ready held high.
        ack_dly = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_adr = 16'h0001; bus.rsp_ready = 1'b1;
        n_acc = 0; n_rsp = 0; acc[0] = 0; acc[1] = 0;
        for (int c = 0; c < 40; c++) begin
            if (n_acc == 2) bus.cmd_valid = 1'b0;
            else if (bus.cmd_valid && bus.cmd_ready) begin
                acc[n_acc] = c;
                n_acc++;
            end
            if (bus.rsp_valid) n_rsp++;
            @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        check("b2b_accepts", n_acc, 32'd2);
        check("b2b_period", acc[1] - acc[0], 32'd4);
        check("b2b_responses", n_rsp, 32'd2);

        // Reset while waiting for an ack that never comes.
        never_ack = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_adr = 16'h0003; bus.cmd_dat = 32'h1111_2222;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_wait_stb", {31'd0, bus.wb_stb}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_cyc_stb", {30'd0, bus.wb_cyc, bus.wb_stb}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        rst_n = 1'b1;
        never_ack = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("post_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("post_rst_err_cnt", {16'd0, bus.err_cnt}, 32'd0);
        ack_dly = 0;
        do_cmd(1'b0, 16'h0001, 32'h0, 0, rdat, err, lat, stbc, hok);
        check("recover_rsp_dat", rdat, 32'h0000_5A5A);
        check("recover_latency", lat, 32'd3);

`ifdef WBM_TIMEOUT_EN
        never_ack = 1'b1;
        do_cmd(1'b0, 16'h0001, 32'h0, 0, rdat, err, lat, stbc, hok);
        check("tmo_rsp_dat", rdat, 32'hFFFF_FFFF);
        check("tmo_rsp_err", {31'd0, err}, 32'd1);
        check("tmo_stb_cycles", stbc, TMO);
        check("tmo_err_cnt", {16'd0, bus.err_cnt}, 32'd1);
        never_ack = 1'b0;
        ack_dly = TMO - 2;
        do_cmd(1'b0, 16'h0001, 32'h0, 0, rdat, err, lat, stbc, hok);
        check("edge_rsp_err", {31'd0, err}, 32'd0);
        check("edge_rsp_dat", rdat, 32'h0000_5A5A);
        check("edge_stb_cycles", stbc, TMO);
        check("edge_err_cnt", {16'd0, bus.err_cnt}, 32'd1);
        ack_dly = TMO - 1;
        do_cmd(1'b0, 16'h0001, 32'h0, 0, rdat, err, lat, stbc, hok);
        check("late_rsp_err", {31'd0, err}, 32'd1);
        check("late_err_cnt", {16'd0, bus.err_cnt}, 32'd2);
        @(negedge clk);
        force dut.err_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.err_cnt_q;
        @(negedge clk);
        check("preload_err_cnt", {16'd0, bus.err_cnt}, 32'h0000_FFFE);
        never_ack = 1'b1;
        do_cmd(1'b0, 16'h0001, 32'h0, 0, rdat, err, lat, stbc, hok);
        check("sat_err_cnt_1", {16'd0, bus.err_cnt}, 32'h0000_FFFF);
        do_cmd(1'b0, 16'h0001, 32'h0, 0, rdat, err, lat, stbc, hok);
        check("sat_err_cnt_2", {16'd0, bus.err_cnt}, 32'h0000_FFFF);
        never_ack = 1'b0;
`else
        ack_dly = 300;
        do_cmd(1'b0, 16'h0002, 32'h0, 0, rdat, err, lat, stbc, hok);
        check("long_rsp_dat", rdat, 32'hDEAD_BEEF);
        check("long_rsp_err", {31'd0, err}, 32'd0);
        check("long_latency", lat, 32'd303);
        check("long_stb_cycles", stbc, 32'd302);
        check("long_err_cnt", {16'd0, bus.err_cnt}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
